// File: rtl/cpr_sequencer.sv
// CPR trainer timing controller: repeating N_COMPRESS compressions then N_BREATH breaths, toggled by a pad start input.
// Define CPR_CYCLE_LIMIT_EN to stop in DONE after MAX_CYCLES full cycles.
module cpr_sequencer #(
  parameter int TICK_DIV      = 10000,
  parameter int COMP_PERIOD   = 545,
  parameter int COMP_ON       = 272,
  parameter int N_COMPRESS    = 30,
  parameter int BREATH_PERIOD = 2000,
  parameter int BREATH_ON     = 1000,
  parameter int N_BREATH      = 2,
  parameter int MAX_CYCLES    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        compress_out,
  output logic        breath_out,
  output logic        pulse_out,
  output logic        sync,
  output logic        busy,
  output logic        done,
  output logic [15:0] cycle_count
);

  localparam int PMAX = (COMP_PERIOD > BREATH_PERIOD) ? COMP_PERIOD : BREATH_PERIOD;
  localparam int NMAX = (N_COMPRESS > N_BREATH) ? N_COMPRESS : N_BREATH;
  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int RW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  localparam logic [TW-1:0] TICK_LAST       = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] COMP_LAST       = PW'(COMP_PERIOD - 1);
  localparam logic [PW-1:0] COMP_ON_CNT     = PW'(COMP_ON);
  localparam logic [PW-1:0] BREATH_LAST     = PW'(BREATH_PERIOD - 1);
  localparam logic [PW-1:0] BREATH_ON_CNT   = PW'(BREATH_ON);
  localparam logic [RW-1:0] COMP_REP_LAST   = RW'(N_COMPRESS - 1);
  localparam logic [RW-1:0] BREATH_REP_LAST = RW'(N_BREATH - 1);
  localparam logic [15:0]   CYCLE_LIMIT     = 16'(MAX_CYCLES);

`ifdef CPR_CYCLE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPRESS = 2'd1,
    BREATH   = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] presc, presc_next;
  logic [PW-1:0] pcnt, pcnt_next, pcnt_inc;
  logic [RW-1:0] rep, rep_next;
  logic [15:0]   cc_next, cc_inc;
  logic          compress_next, breath_next, pulse_next, sync_next;
  logic          busy_next, done_next;
  logic          s1, s2, s3;
  logic          start_rise;
  logic          tick;

  // Two flops resolve metastability on the pad input; s3 delays s2 for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= start;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign start_rise = s2 & ~s3;
  assign tick       = (presc == TICK_LAST);
  assign pcnt_inc   = pcnt + 1'b1;
  assign cc_inc     = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      presc        <= '0;
      pcnt         <= '0;
      rep          <= '0;
      cycle_count  <= '0;
      compress_out <= 1'b0;
      breath_out   <= 1'b0;
      pulse_out    <= 1'b0;
      sync         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      presc        <= presc_next;
      pcnt         <= pcnt_next;
      rep          <= rep_next;
      cycle_count  <= cc_next;
      compress_out <= compress_next;
      breath_out   <= breath_next;
      pulse_out    <= pulse_next;
      sync         <= sync_next;
      busy         <= busy_next;
      done         <= done_next;
    end
  end

  // Outputs are computed for the next state so each drive edge lines up with its counter edge.
  always_comb begin
    state_next    = state;
    presc_next    = presc;
    pcnt_next     = pcnt;
    rep_next      = rep;
    cc_next       = cycle_count;
    compress_next = 1'b0;
    breath_next   = 1'b0;
    pulse_next    = 1'b0;
    sync_next     = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start_rise) begin
          state_next    = COMPRESS;
          presc_next    = '0;
          pcnt_next     = '0;
          rep_next      = '0;
          cc_next       = '0;
          compress_next = 1'b1;
          pulse_next    = 1'b1;
          sync_next     = 1'b1;
        end
      end

      COMPRESS: begin
        if (start_rise) begin
          state_next = IDLE;
          presc_next = '0;
          pcnt_next  = '0;
          rep_next   = '0;
        end else begin
          presc_next    = tick ? '0 : presc + 1'b1;
          compress_next = (pcnt < COMP_ON_CNT);
          if (tick) begin
            if (pcnt != COMP_LAST) begin
              pcnt_next     = pcnt_inc;
              compress_next = (pcnt_inc < COMP_ON_CNT);
            end else begin
              pcnt_next = '0;
              if (rep != COMP_REP_LAST) begin
                rep_next      = rep + 1'b1;
                compress_next = 1'b1;
                pulse_next    = 1'b1;
              end else begin
                rep_next      = '0;
                state_next    = BREATH;
                compress_next = 1'b0;
                breath_next   = 1'b1;
              end
            end
          end
        end
      end

      BREATH: begin
        if (start_rise) begin
          state_next = IDLE;
          presc_next = '0;
          pcnt_next  = '0;
          rep_next   = '0;
        end else begin
          presc_next  = tick ? '0 : presc + 1'b1;
          breath_next = (pcnt < BREATH_ON_CNT);
          if (tick) begin
            if (pcnt != BREATH_LAST) begin
              pcnt_next   = pcnt_inc;
              breath_next = (pcnt_inc < BREATH_ON_CNT);
            end else begin
              pcnt_next = '0;
              if (rep != BREATH_REP_LAST) begin
                rep_next    = rep + 1'b1;
                breath_next = 1'b1;
              end else begin
                rep_next    = '0;
                cc_next     = cc_inc;
                breath_next = 1'b0;
                if (LIMIT_EN && (cc_inc >= CYCLE_LIMIT)) begin
                  state_next = DONE;
                  presc_next = '0;
                end else begin
                  state_next    = COMPRESS;
                  compress_next = 1'b1;
                  pulse_next    = 1'b1;
                  sync_next     = 1'b1;
                end
              end
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next == COMPRESS) || (state_next == BREATH);
    done_next = LIMIT_EN && (state_next == DONE);
  end

endmodule

// File: tb/tb_cpr_sequencer.sv
// Bench for cpr_sequencer: time-based waveform model plus hand-computed checkpoints.
module tb_cpr_sequencer;

  localparam int TD = 4, CP = 5, CON = 2, NC = 3, BP = 6, BON = 3, NB = 2, MAXC = 2;
  localparam int CPH = NC * CP * TD;        // 60 clks of compression per cycle
  localparam int CL  = CPH + NB * BP * TD;  // 108 clks per full cycle
`ifdef CPR_CYCLE_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        compress_out, breath_out, pulse_out, sync, busy, done;
  logic [15:0] cycle_count;

  int vectors = 0;
  int miscompares = 0;

  cpr_sequencer #(
    .TICK_DIV(TD), .COMP_PERIOD(CP), .COMP_ON(CON), .N_COMPRESS(NC),
    .BREATH_PERIOD(BP), .BREATH_ON(BON), .N_BREATH(NB), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .compress_out(compress_out), .breath_out(breath_out), .pulse_out(pulse_out),
    .sync(sync), .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Model: a start edge first sampled at edge k takes effect at edge k+2;
  // while running, m_t is the clock index within the current full cycle.
  bit       m_run, m_done, m_ev, prev_s;
  bit [1:0] ev_pipe;
  int       m_t, m_cc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_done = 0; m_t = 0; m_cc = 0; prev_s = 0; ev_pipe = 2'b00;
    end else begin
      m_ev    = ev_pipe[1];
      ev_pipe = {ev_pipe[0], (start === 1'b1) && !prev_s};
      prev_s  = (start === 1'b1);
      if (m_ev) begin
        if (m_run) m_run = 0;
        else begin
          m_run = 1; m_done = 0; m_t = 0; m_cc = 0;
        end
      end else if (m_run) begin
        m_t++;
        if (m_t == CL) begin
          m_t = 0;
          if (m_cc < 65535) m_cc++;
          if (LIM && m_cc >= MAXC) begin
            m_run = 0; m_done = 1;
          end
        end
      end
    end
  end

  function automatic logic [21:0] model_out();
    logic c, b, p, s;
    int pos;
    c = 0; b = 0; p = 0; s = 0;
    if (m_run) begin
      if (m_t < CPH) begin
        pos = m_t % (CP * TD);
        c = (pos < CON * TD);
        p = (pos == 0);
      end else begin
        pos = (m_t - CPH) % (BP * TD);
        b = (pos < BON * TD);
      end
      s = (m_t == 0);
    end
    return {c, b, p, s, m_run, m_done, 16'(m_cc)};
  endfunction

  logic [21:0] got_v, exp_v;
  always @(negedge clk) begin
    got_v = {compress_out, breath_out, pulse_out, sync, busy, done, cycle_count};
    exp_v = model_out();
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL model_check @%0t: dut {c,b,p,s,busy,done,cnt}=%h expected %h", $time, got_v, exp_v);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    nclk(2);
    check("reset_compress", compress_out, 0);
    check("reset_busy", busy, 0);
    check("reset_count", cycle_count, 0);
    reset = 1'b0;
    nclk(3);
    check("idle_busy", busy, 0);

    // Start latency and compression shape
    start = 1'b1;
    nclk(2);
    check("pre_latency_compress", compress_out, 0);
    nclk(1);                                             // t=0
    check("first_compress", compress_out, 1);
    check("first_sync", sync, 1);
    check("first_pulse", pulse_out, 1);
    start = 1'b0;
    nclk(1);                                             // t=1
    check("sync_one_clk", sync, 0);
    check("pulse_one_clk", pulse_out, 0);
    nclk(6);                                             // t=7
    check("compress_last_high", compress_out, 1);
    nclk(1);                                             // t=8
    check("compress_low_at_8", compress_out, 0);
    nclk(12);                                            // t=20
    check("second_compress", compress_out, 1);
    check("second_pulse", pulse_out, 1);

    // Breath phase and cycle wrap
    nclk(40);                                            // t=60
    check("breath_start", breath_out, 1);
    check("compress_off_in_breath", compress_out, 0);
    nclk(12);                                            // t=72
    check("breath_low_at_72", breath_out, 0);
    nclk(36);                                            // t=108
    check("cycle_sync", sync, 1);
    check("cycle_compress", compress_out, 1);
    check("cycle_count_1", cycle_count, 1);

    // Stop mid-breath, then restart
    nclk(70);                                            // r=70, breath high
    check("breath_before_stop", breath_out, 1);
    start = 1'b1;
    nclk(2);
    check("busy_before_stop", busy, 1);
    nclk(1);
    check("stop_busy", busy, 0);
    check("stop_breath", breath_out, 0);
    check("stop_count_held", cycle_count, 1);
    start = 1'b0;
    nclk(5);
    start = 1'b1;
    nclk(3);
    check("restart_compress", compress_out, 1);
    check("restart_count", cycle_count, 0);
    start = 1'b0;

    // Async reset mid-compression
    nclk(3);
    check("compress_before_reset", compress_out, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_compress", compress_out, 0);
    check("async_reset_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    nclk(20);
    check("post_reset_idle", busy, 0);

    // Long start pulse counts once; held-low start keeps running
    start = 1'b1;
    nclk(10);
    start = 1'b0;
    nclk(20);
    check("glitch_single_event", busy, 1);
    nclk(50);
    check("start_low_holds", busy, 1);
    start = 1'b1;
    nclk(3);
    check("stop_again", busy, 0);
    start = 1'b0;
    nclk(5);

    // Two full cycles from a fresh start
    start = 1'b1;
    nclk(3);
    check("run2_compress", compress_out, 1);
    start = 1'b0;
    nclk(216);
    if (LIM) begin
      check("limit_done", done, 1);
      check("limit_busy", busy, 0);
      check("limit_count", cycle_count, 2);
      check("limit_compress", compress_out, 0);
      start = 1'b1;
      nclk(3);
      check("limit_restart_done", done, 0);
      check("limit_restart_compress", compress_out, 1);
    end else begin
      check("nolimit_sync", sync, 1);
      check("nolimit_count", cycle_count, 2);
      check("nolimit_done", done, 0);
      start = 1'b1;
      nclk(3);
      check("nolimit_stop", busy, 0);
    end
    start = 1'b0;
    nclk(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
